// File: rtl/firebird_regfile_wr_arbiter_pkg.sv
// Types and helpers for the regfile write-port arbiter.
// Register geometry comes from the shared firebird defines.
`ifndef FIREBIRD_REG_SIZE
`include "firebird_defines.sv"
`endif

package firebird_regfile_wr_arbiter_pkg;

    localparam int REG_ADDR_W = `FIREBIRD_REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = `FIREBIRD_ZERO_REG;

    // Next round-robin position after index g among n requesters.
    function automatic int unsigned rr_next(
        input int unsigned g,
        input int unsigned n
    );
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/firebird_defines.sv
// Shared firebird core constants.
// Register file geometry used by every datapath block.
`ifndef FIREBIRD_DEFINES_SV
`define FIREBIRD_DEFINES_SV

`define FIREBIRD_REG_SIZE 32
`define FIREBIRD_REG_ADDR_W 5
`define FIREBIRD_ZERO_REG 5'd0

`endif

// File: rtl/firebird_rr_arbiter.sv
// Round-robin picker: valid vector + priority pointer
// to one-hot grant and encoded winner index.
module firebird_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] sel;

    // Scan from the pointer upward; first valid requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = IDX_W'((int'(ptr) + k) % NREQ);
            if (!any && valid[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/firebird_regfile_wr_arbiter.sv
// Shares the regfile write port among NREQ requesters with
// round-robin grants, x0 filtering and flush gating.
module firebird_regfile_wr_arbiter
    import firebird_regfile_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int XLEN  = `FIREBIRD_REG_SIZE,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0]       req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       we,
    output reg_addr_t                  waddr,
    output logic [XLEN-1:0]            wdata,
    output logic [IDX_W-1:0]           last_grant
);

    logic [IDX_W-1:0] rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] win;
    logic             win_any;
    logic             accept;
    reg_addr_t        addr_g;
    logic [XLEN-1:0]  data_g;

    firebird_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win),
        .any   (win_any)
    );

    // Ready is held low while reset is asserted so nothing
    // is acknowledged that the output register cannot take.
    always_comb begin
        req_ready = grant & {NREQ{reset}};
        accept    = win_any & reset;
        addr_g    = req_addr[win*REG_ADDR_W +: REG_ADDR_W];
        data_g    = req_data[win*XLEN +: XLEN];
    end

    // Pointer, debug index and the registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            last_grant <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            we <= accept & (addr_g != ZERO_REG) & ~flush;
            if (accept) begin
                rr_ptr     <= IDX_W'(rr_next(32'(win), NREQ));
                last_grant <= win;
                waddr      <= addr_g;
                wdata      <= data_g;
            end
        end
    end

endmodule
